// File: rtl/ahb_apb_pkg.sv
// Shared AHB encodings, bridge front-end states and default region map
// for the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] DEF_BASE_ADDR    = 32'h8000_0000;
    localparam int          DEF_REGION_SHIFT = 26;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DPH  = 3'd1,
        ST_REQ  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational region decoder: NSLV equal regions of 2**REGION_SHIFT bytes
// starting at BASE_ADDR; anything below the base or past the last region is unmapped.
module ahb_addr_decode #(
    parameter int                ADDR_W       = 32,
    parameter int                NSLV         = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h8000_0000),
    parameter int                REGION_SHIFT = 26
) (
    input  logic [ADDR_W-1:0] haddr,
    output logic              mapped,
    output logic [NSLV-1:0]   sel
);

    logic [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] idx_s;

    // Full-width offset and region index; the lower-bound test stops wrap below the base
    always_comb begin
        off_s  = haddr - BASE_ADDR;
        idx_s  = off_s >> REGION_SHIFT;
        mapped = (haddr >= BASE_ADDR) && (idx_s < ADDR_W'(NSLV));
        sel    = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel[i] = mapped && (idx_s == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: captures one transfer at a
// time, hands it to the APB FSM over xfer_valid/xfer_done and stalls the bus meanwhile.
module ahb_slave_if_param
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                NSLV         = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
    parameter int                REGION_SHIFT = DEF_REGION_SHIFT
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              xfer_valid,
    output logic              xfer_write,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic [DATA_W-1:0] xfer_wdata,
    output logic [NSLV-1:0]   xfer_sel,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] xfer_rdata,
    input  logic              xfer_err
);

    state_t            state_q, state_d;
    logic              hreadyout_q, hreadyout_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              xfer_valid_q, xfer_valid_d;
    logic              xfer_write_q, xfer_write_d;
    logic [ADDR_W-1:0] xfer_addr_q, xfer_addr_d;
    logic [DATA_W-1:0] xfer_wdata_q, xfer_wdata_d;
    logic [NSLV-1:0]   xfer_sel_q, xfer_sel_d;
    logic              capture_s;
    logic              dec_mapped_s;
    logic [NSLV-1:0]   dec_sel_s;

    ahb_addr_decode #(
        .ADDR_W      (ADDR_W),
        .NSLV        (NSLV),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_SHIFT(REGION_SHIFT)
    ) u_decode (
        .haddr (haddr),
        .mapped(dec_mapped_s),
        .sel   (dec_sel_s)
    );

    // Next state, capture registers, and bus/handshake outputs decoded from the next state
    always_comb begin
        state_d      = state_q;
        hrdata_d     = hrdata_q;
        xfer_write_d = xfer_write_q;
        xfer_addr_d  = xfer_addr_q;
        xfer_wdata_d = xfer_wdata_q;
        xfer_sel_d   = xfer_sel_q;
        hreadyout_d  = 1'b1;
        hresp_d      = HRESP_OKAY;
        xfer_valid_d = 1'b0;
        // hreadyout_q is only high in IDLE, DONE and ERR2, so capture is confined there
        capture_s    = hreadyin && hreadyout_q &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (capture_s) begin
                    if (dec_mapped_s) begin
                        state_d      = ST_DPH;
                        xfer_write_d = hwrite;
                        xfer_addr_d  = haddr;
                        xfer_sel_d   = dec_sel_s;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DPH: begin
                if (xfer_write_q) begin
                    xfer_wdata_d = hwdata;
                end else begin
                    xfer_wdata_d = xfer_wdata_q;
                end
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (xfer_done) begin
                    if (!xfer_write_q) begin
                        hrdata_d = xfer_rdata;
                    end else begin
                        hrdata_d = hrdata_q;
                    end
                    state_d = xfer_err ? ST_ERR1 : ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE, ST_DONE: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
            ST_DPH: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_OKAY;
            end
            ST_REQ: begin
                hreadyout_d  = 1'b0;
                hresp_d      = HRESP_OKAY;
                xfer_valid_d = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            ST_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer at once
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            hreadyout_q  <= 1'b1;
            hresp_q      <= HRESP_OKAY;
            hrdata_q     <= '0;
            xfer_valid_q <= 1'b0;
            xfer_write_q <= 1'b0;
            xfer_addr_q  <= '0;
            xfer_wdata_q <= '0;
            xfer_sel_q   <= '0;
        end else begin
            state_q      <= state_d;
            hreadyout_q  <= hreadyout_d;
            hresp_q      <= hresp_d;
            hrdata_q     <= hrdata_d;
            xfer_valid_q <= xfer_valid_d;
            xfer_write_q <= xfer_write_d;
            xfer_addr_q  <= xfer_addr_d;
            xfer_wdata_q <= xfer_wdata_d;
            xfer_sel_q   <= xfer_sel_d;
        end
    end

    assign hreadyout  = hreadyout_q;
    assign hresp      = hresp_q;
    assign hrdata     = hrdata_q;
    assign xfer_valid = xfer_valid_q;
    assign xfer_write = xfer_write_q;
    assign xfer_addr  = xfer_addr_q;
    assign xfer_wdata = xfer_wdata_q;
    assign xfer_sel   = xfer_sel_q;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Bench for ahb_slave_if_param: two instances (NSLV=3/shift 26 and NSLV=8/shift 20)
// checked every cycle against a queue-based response model plus directed literal pins.
module tb_ahb_slave_if_param;
    import ahb_apb_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic        hwrite_s;
    logic        hreadyin_s;
    logic [1:0]  htrans_s;
    logic [31:0] haddr_s;
    logic [31:0] hwdata_s;
    logic        done_s;
    logic [31:0] rdata_s;
    logic        err_s;
    int          cur;

    logic [1:0]        htr0, htr1;
    logic              done0, done1;
    logic [1:0]        ready_o;
    logic [1:0][1:0]   resp_o;
    logic [1:0][31:0]  rdata_o;
    logic [1:0]        valid_o;
    logic [1:0]        write_o;
    logic [1:0][31:0]  addr_o;
    logic [1:0][31:0]  wdata_o;
    logic [1:0][7:0]   sel_o;
    logic [2:0]        sel0;
    logic [7:0]        sel1;

    assign htr0  = (cur == 0) ? htrans_s : HTRANS_IDLE;
    assign htr1  = (cur == 1) ? htrans_s : HTRANS_IDLE;
    assign done0 = done_s && (cur == 0);
    assign done1 = done_s && (cur == 1);
    assign sel_o[0] = {5'b00000, sel0};
    assign sel_o[1] = sel1;

    ahb_slave_if_param u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite_s), .hreadyin(hreadyin_s),
        .htrans(htr0), .haddr(haddr_s), .hwdata(hwdata_s),
        .hreadyout(ready_o[0]), .hresp(resp_o[0]), .hrdata(rdata_o[0]),
        .xfer_valid(valid_o[0]), .xfer_write(write_o[0]), .xfer_addr(addr_o[0]),
        .xfer_wdata(wdata_o[0]), .xfer_sel(sel0),
        .xfer_done(done0), .xfer_rdata(rdata_s), .xfer_err(err_s)
    );

    ahb_slave_if_param #(.NSLV(8), .REGION_SHIFT(20)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite_s), .hreadyin(hreadyin_s),
        .htrans(htr1), .haddr(haddr_s), .hwdata(hwdata_s),
        .hreadyout(ready_o[1]), .hresp(resp_o[1]), .hrdata(rdata_o[1]),
        .xfer_valid(valid_o[1]), .xfer_write(write_o[1]), .xfer_addr(addr_o[1]),
        .xfer_wdata(wdata_o[1]), .xfer_sel(sel1),
        .xfer_done(done1), .xfer_rdata(rdata_s), .xfer_err(err_s)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // ---------------- model: pending bus responses per instance ----------------
    bit          m_rdy   [2];
    bit [1:0]    m_rsp   [2];
    bit          m_val   [2];
    bit          m_dph   [2];
    bit          m_await [2];
    bit          m_wr    [2];
    bit [31:0]   m_rdata [2];
    bit [31:0]   m_addr  [2];
    bit [31:0]   m_wdata [2];
    bit [7:0]    m_sel   [2];
    int          pn      [2];
    bit          pr_rdy  [2][4];
    bit [1:0]    pr_rsp  [2][4];
    bit          pr_dph  [2][4];
    bit          mp;
    longint unsigned aa, idx;

    task automatic push(input int k, input bit r, input bit [1:0] s, input bit d);
        pr_rdy[k][pn[k]] = r;
        pr_rsp[k][pn[k]] = s;
        pr_dph[k][pn[k]] = d;
        pn[k]++;
    endtask

    initial begin
        forever begin
            @(posedge hclk or negedge hresetn);
            for (int k = 0; k < 2; k++) begin
                if (!hresetn) begin
                    m_rdy[k] = 1'b1; m_rsp[k] = 2'b00; m_val[k] = 1'b0; m_dph[k] = 1'b0;
                    m_await[k] = 1'b0; m_wr[k] = 1'b0; m_rdata[k] = 32'h0;
                    m_addr[k] = 32'h0; m_wdata[k] = 32'h0; m_sel[k] = 8'h00; pn[k] = 0;
                end else begin
                    if (m_dph[k] && m_wr[k]) m_wdata[k] = hwdata_s;
                    if (m_val[k] && done_s && cur == k) begin
                        m_await[k] = 1'b0;
                        if (!m_wr[k]) m_rdata[k] = rdata_s;
                        if (err_s) begin
                            push(k, 1'b0, 2'b01, 1'b0);
                            push(k, 1'b1, 2'b01, 1'b0);
                        end else begin
                            push(k, 1'b1, 2'b00, 1'b0);
                        end
                    end
                    if (cur == k && hreadyin_s && m_rdy[k] && htrans_s[1]) begin
                        aa  = {32'h0, haddr_s};
                        idx = (aa - 64'h8000_0000) >> ((k == 0) ? 26 : 20);
                        mp  = (aa >= 64'h8000_0000) && (idx < ((k == 0) ? 64'd3 : 64'd8));
                        if (mp) begin
                            m_addr[k]  = haddr_s;
                            m_wr[k]    = hwrite_s;
                            m_sel[k]   = 8'd1 << idx;
                            m_await[k] = 1'b1;
                            push(k, 1'b0, 2'b00, 1'b1);
                        end else begin
                            push(k, 1'b0, 2'b01, 1'b0);
                            push(k, 1'b1, 2'b01, 1'b0);
                        end
                    end
                    if (pn[k] > 0) begin
                        m_rdy[k] = pr_rdy[k][0]; m_rsp[k] = pr_rsp[k][0];
                        m_dph[k] = pr_dph[k][0]; m_val[k] = 1'b0;
                        for (int j = 0; j < 3; j++) begin
                            pr_rdy[k][j] = pr_rdy[k][j+1];
                            pr_rsp[k][j] = pr_rsp[k][j+1];
                            pr_dph[k][j] = pr_dph[k][j+1];
                        end
                        pn[k]--;
                    end else if (m_await[k]) begin
                        m_rdy[k] = 1'b0; m_rsp[k] = 2'b00; m_dph[k] = 1'b0; m_val[k] = 1'b1;
                    end else begin
                        m_rdy[k] = 1'b1; m_rsp[k] = 2'b00; m_dph[k] = 1'b0; m_val[k] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int          n_checks;
    int          n_errors;
    bit          lit_en;
    string       lit_name;
    logic [31:0] lit_got, lit_exp;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d t=%0t: got %h, expected %h", nm, k, $time, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        forever begin
            @(negedge hclk);
            for (int k = 0; k < 2; k++) begin
                if (!hresetn) begin
                    chk("rst_hreadyout", k, 32'(ready_o[k]), 32'd1);
                    chk("rst_hresp", k, 32'(resp_o[k]), 32'd0);
                    chk("rst_xfer_valid", k, 32'(valid_o[k]), 32'd0);
                    chk("rst_hrdata", k, rdata_o[k], 32'd0);
                    chk("rst_xfer_sel", k, 32'(sel_o[k]), 32'd0);
                    chk("rst_xfer_addr", k, addr_o[k], 32'd0);
                    chk("rst_xfer_wdata", k, wdata_o[k], 32'd0);
                    chk("rst_xfer_write", k, 32'(write_o[k]), 32'd0);
                end else begin
                    chk("hreadyout", k, 32'(ready_o[k]), 32'(m_rdy[k]));
                    chk("hresp", k, 32'(resp_o[k]), 32'(m_rsp[k]));
                    chk("xfer_valid", k, 32'(valid_o[k]), 32'(m_val[k]));
                    chk("hrdata", k, rdata_o[k], m_rdata[k]);
                    if (m_val[k]) begin
                        chk("xfer_sel", k, 32'(sel_o[k]), 32'(m_sel[k]));
                        chk("xfer_addr", k, addr_o[k], m_addr[k]);
                        chk("xfer_write", k, 32'(write_o[k]), 32'(m_wr[k]));
                        if (m_wr[k]) chk("xfer_wdata", k, wdata_o[k], m_wdata[k]);
                    end
                end
            end
            if (lit_en) chk(lit_name, cur, lit_got, lit_exp);
        end
    end

    // ---------------- stimulus ----------------
    int          r_waits;
    bit          r_saw_valid;
    logic [7:0]  r_sel;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;

    task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
        lit_name = nm;
        lit_got  = got;
        lit_exp  = exp;
        lit_en   = 1'b1;
        @(negedge hclk);
        #1;
        lit_en   = 1'b0;
    endtask

    task automatic sync();
        @(posedge hclk);
        #1;
    endtask

    // Caller must be at posedge+1 of a cycle with hreadyout=1
    task automatic ahb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input int dly, input logic [31:0] rd, input bit er);
        int reqn;
        int guard;
        htrans_s = HTRANS_NONSEQ;
        hwrite_s = wr;
        haddr_s  = addr;
        sync();
        htrans_s = HTRANS_IDLE;
        hwdata_s = wd;
        r_waits = 0; r_saw_valid = 1'b0; reqn = 0; guard = 0;
        r_sel = 8'h00; r_wdata = 32'h0; r_write = 1'b0;
        while (!ready_o[cur] && guard < 64) begin
            r_waits++;
            guard++;
            if (valid_o[cur]) begin
                if (!r_saw_valid) begin
                    r_sel = sel_o[cur]; r_wdata = wdata_o[cur]; r_write = write_o[cur];
                end
                r_saw_valid = 1'b1;
                if (reqn == dly) begin
                    done_s = 1'b1; rdata_s = rd; err_s = er;
                end
                reqn++;
            end
            sync();
            done_s = 1'b0;
            err_s  = 1'b0;
        end
        r_resp  = resp_o[cur];
        r_rdata = rdata_o[cur];
        if (guard >= 64) post("xfer_timeout", 32'd1, 32'd0);
    endtask

    logic [7:0] s1;
    logic       v_s, r_s;

    initial begin
        hresetn = 1'b0; hwrite_s = 1'b0; hreadyin_s = 1'b1; htrans_s = HTRANS_IDLE;
        haddr_s = 32'h0; hwdata_s = 32'h0; done_s = 1'b0; rdata_s = 32'h0; err_s = 1'b0;
        cur = 0; lit_en = 1'b0; lit_name = ""; lit_got = 32'h0; lit_exp = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        post("lit_rst_ready", 32'(ready_o[0]), 32'd1);
        post("lit_rst_sel", 32'(sel_o[0]), 32'd0);
        sync();
        hresetn = 1'b1;
        sync();

        // 1: write, done in third request cycle
        ahb_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        post("t1_sel", 32'(r_sel), 32'h1);
        post("t1_wdata", r_wdata, 32'hDEAD_BEEF);
        post("t1_write", 32'(r_write), 32'd1);
        post("t1_waits", 32'(r_waits), 32'd4);
        post("t1_hresp", 32'(r_resp), 32'd0);
        sync();
        // 2: read, done on first request cycle
        ahb_xfer(1'b0, 32'h8400_0004, 32'h0, 0, 32'h1234_5678, 1'b0);
        post("t2_sel", 32'(r_sel), 32'h2);
        post("t2_hrdata", r_rdata, 32'h1234_5678);
        post("t2_waits", 32'(r_waits), 32'd2);
        sync();
        // 3: unmapped above and below the map
        ahb_xfer(1'b0, 32'h8C00_0000, 32'h0, 0, 32'h0, 1'b0);
        post("t3a_valid", 32'(r_saw_valid), 32'd0);
        post("t3a_waits", 32'(r_waits), 32'd1);
        post("t3a_hresp", 32'(r_resp), 32'd1);
        sync();
        ahb_xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 0, 32'h0, 1'b0);
        post("t3b_valid", 32'(r_saw_valid), 32'd0);
        post("t3b_hresp", 32'(r_resp), 32'd1);
        sync();
        ahb_xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 1'b0);
        post("t3c_valid", 32'(r_saw_valid), 32'd0);
        sync();
        ahb_xfer(1'b0, 32'h8BFF_FFFC, 32'h0, 0, 32'h5555_AAAA, 1'b0);
        post("t3d_sel", 32'(r_sel), 32'h4);
        sync();
        // 4: back-to-back writes captured in DONE
        ahb_xfer(1'b1, 32'h8800_0000, 32'h1111_1111, 0, 32'h0, 1'b0);
        s1 = r_sel;
        ahb_xfer(1'b1, 32'h8000_0000, 32'h2222_2222, 0, 32'h0, 1'b0);
        post("t4_sel_first", 32'(s1), 32'h4);
        post("t4_sel_second", 32'(r_sel), 32'h1);
        post("t4_wdata_second", r_wdata, 32'h2222_2222);
        post("t4_waits_second", 32'(r_waits), 32'd2);
        sync();
        // 5: APB error on a read, then a clean read
        ahb_xfer(1'b0, 32'h8000_0100, 32'h0, 0, 32'hBAD0_0001, 1'b1);
        post("t5_err_waits", 32'(r_waits), 32'd3);
        post("t5_err_hresp", 32'(r_resp), 32'd1);
        sync();
        ahb_xfer(1'b0, 32'h8800_0008, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
        post("t5_ok_hresp", 32'(r_resp), 32'd0);
        post("t5_ok_hrdata", r_rdata, 32'hCAFE_F00D);
        sync();
        // 6: reset during REQ
        htrans_s = HTRANS_NONSEQ; hwrite_s = 1'b1; haddr_s = 32'h8000_0020;
        sync();
        htrans_s = HTRANS_IDLE; hwdata_s = 32'h0BAD_F00D;
        sync();
        v_s = valid_o[0];
        hresetn = 1'b0;
        #1;
        post("t6_valid_before", 32'(v_s), 32'd1);
        v_s = valid_o[0];
        r_s = ready_o[0];
        post("t6_valid_rst", 32'(v_s), 32'd0);
        post("t6_ready_rst", 32'(r_s), 32'd1);
        sync();
        hresetn = 1'b1;
        sync();
        done_s = 1'b1;
        sync();
        done_s = 1'b0;
        sync();
        post("t6_late_done_valid", 32'(valid_o[0]), 32'd0);
        sync();

        // NSLV=8, REGION_SHIFT=20 instance
        cur = 1;
        sync();
        ahb_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        post("p8_t1_sel", 32'(r_sel), 32'h01);
        post("p8_t1_waits", 32'(r_waits), 32'd4);
        sync();
        ahb_xfer(1'b0, 32'h8010_0004, 32'h0, 0, 32'h1234_5678, 1'b0);
        post("p8_t2_sel", 32'(r_sel), 32'h02);
        post("p8_t2_hrdata", r_rdata, 32'h1234_5678);
        post("p8_t2_waits", 32'(r_waits), 32'd2);
        sync();
        ahb_xfer(1'b0, 32'h8080_0000, 32'h0, 0, 32'h0, 1'b0);
        post("p8_t3a_valid", 32'(r_saw_valid), 32'd0);
        post("p8_t3a_hresp", 32'(r_resp), 32'd1);
        sync();
        ahb_xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 0, 32'h0, 1'b0);
        post("p8_t3b_valid", 32'(r_saw_valid), 32'd0);
        sync();
        ahb_xfer(1'b0, 32'h807F_FFFC, 32'h0, 0, 32'h7777_0000, 1'b0);
        post("p8_t3c_sel", 32'(r_sel), 32'h80);
        post("p8_t3c_hrdata", r_rdata, 32'h7777_0000);
        repeat (3) sync();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
